// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state type, data width and the clocks-per-bit helper.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
`ifdef UART_RX_PARITY_EN
      PARITY,
`endif
      STOP
   } uartState_t;

   function automatic int clksPerBit(input int clkFreq, input int baudRate);
      return clkFreq / baudRate;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, received byte and status pulses out.
interface uart_rx_if;
   logic       dataIn;
   logic [7:0] dataOut;
   logic       validOut;
   logic       frameErrOut;
   logic       parityErrOut;
   logic       busyOut;

   modport master (
      output dataIn,
      input  dataOut, validOut, frameErrOut, parityErrOut, busyOut
   );

   modport slave (
      input  dataIn,
      output dataOut, validOut, frameErrOut, parityErrOut, busyOut
   );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit; reset value is parameterized.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clkIn,
   input  logic rstnIn,
   input  logic asyncIn,
   output logic syncOut
);

   logic meta;

   always_ff @(posedge clkIn or negedge rstnIn) begin
      if (!rstnIn) begin
         meta    <= RESET_VAL;
         syncOut <= RESET_VAL;
      end else begin
         meta    <= asyncIn;
         syncOut <= meta;
      end
   end

endmodule

// File: rtl/uart_rx.sv
// 8-bit UART receiver, mid-bit sampling on a synchronized line, LSB first.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ  = 27000000,
   parameter int BAUD_RATE = 115200
) (
   input  logic     clkIn,
   input  logic     rstnIn,
   uart_rx_if.slave rxBus
);

   localparam int CLKS_PER_BIT = clksPerBit(CLK_FREQ, BAUD_RATE);
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int IDX_W        = $clog2(DATA_BITS);
   localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

   generate
      if (CLKS_PER_BIT < 4) begin : gBadBaud
         $error("uart_rx: CLK_FREQ/BAUD_RATE must be at least 4");
      end
   endgenerate

   logic                 lineSync;
   logic                 lineDly;
   uartState_t           stateReg;
   logic [CNT_W-1:0]     cntReg;
   logic [IDX_W-1:0]     bitIdxReg;
   logic [DATA_BITS-1:0] shiftReg;
   logic [DATA_BITS-1:0] dataReg;
   logic                 validReg;
   logic                 frameErrReg;
`ifdef UART_RX_PARITY_EN
   logic                 parityErrReg;
   logic                 parityBadReg;
`endif

   sync_2ff #(.RESET_VAL(1'b1)) uSync (
      .clkIn   (clkIn),
      .rstnIn  (rstnIn),
      .asyncIn (rxBus.dataIn),
      .syncOut (lineSync)
   );

   always_ff @(posedge clkIn or negedge rstnIn) begin
      if (!rstnIn) begin
         lineDly      <= 1'b1;
         stateReg     <= IDLE;
         cntReg       <= '0;
         bitIdxReg    <= '0;
         shiftReg     <= '0;
         dataReg      <= '0;
         validReg     <= 1'b0;
         frameErrReg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parityErrReg <= 1'b0;
         parityBadReg <= 1'b0;
`endif
      end else begin
         // Edge history runs in every state so a start bit right after mid-stop is seen.
         lineDly      <= lineSync;
         validReg     <= 1'b0;
         frameErrReg  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         parityErrReg <= 1'b0;
`endif
         case (stateReg)
            IDLE: begin
               if (lineDly && !lineSync) begin
                  stateReg <= START;
                  cntReg   <= '0;
               end
            end
            START: begin
               if (cntReg == CNT_HALF) begin
                  cntReg    <= '0;
                  bitIdxReg <= '0;
                  stateReg  <= lineSync ? IDLE : DATA;
               end else begin
                  cntReg <= cntReg + CNT_W'(1);
               end
            end
            DATA: begin
               if (cntReg == CNT_FULL) begin
                  cntReg    <= '0;
                  shiftReg  <= {lineSync, shiftReg[DATA_BITS-1:1]};
                  bitIdxReg <= bitIdxReg + IDX_W'(1);
                  if (bitIdxReg == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                     stateReg <= PARITY;
`else
                     stateReg <= STOP;
`endif
                  end
               end else begin
                  cntReg <= cntReg + CNT_W'(1);
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (cntReg == CNT_FULL) begin
                  cntReg       <= '0;
                  parityBadReg <= (lineSync != ^shiftReg);
                  stateReg     <= STOP;
               end else begin
                  cntReg <= cntReg + CNT_W'(1);
               end
            end
`endif
            STOP: begin
               if (cntReg == CNT_FULL) begin
                  cntReg   <= '0;
                  stateReg <= IDLE;
`ifdef UART_RX_PARITY_EN
                  if (parityBadReg) begin
                     parityErrReg <= 1'b1;
                  end else
`endif
                  if (!lineSync) begin
                     frameErrReg <= 1'b1;
                  end else begin
                     validReg <= 1'b1;
                     dataReg  <= shiftReg;
                  end
               end else begin
                  cntReg <= cntReg + CNT_W'(1);
               end
            end
            default: stateReg <= IDLE;
         endcase
      end
   end

   assign rxBus.dataOut     = dataReg;
   assign rxBus.validOut    = validReg;
   assign rxBus.frameErrOut = frameErrReg;
   assign rxBus.busyOut     = (stateReg != IDLE);
`ifdef UART_RX_PARITY_EN
   assign rxBus.parityErrOut = parityErrReg;
`else
   assign rxBus.parityErrOut = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are modelled as byte/parity/stop-bit tuples,
// expected events are queued at stimulus time and popped by an output monitor.
module tb_uart_rx;

   localparam int CLK_FREQ = 27000000;
   localparam int BAUD     = 115200;
   localparam int CPB      = CLK_FREQ / BAUD;
   localparam int HALF     = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 2 + HALF + 10 * CPB + 1;
`else
   localparam int LAT = 2 + HALF + 9 * CPB + 1;
`endif

   typedef enum int {EV_VALID = 0, EV_FERR = 1, EV_PERR = 2} evKind_t;
   typedef struct {
      evKind_t    kind;
      logic [7:0] data;
      longint     startCyc;
   } expEv_t;

   logic   clk  = 1'b0;
   logic   rstn = 1'b0;
   longint cyc  = 0;
   int     tests = 0;
   int     fails = 0;
   expEv_t sbQ[$];
   logic [7:0] lastGood = 8'h00;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   uart_rx_if bus ();

   uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD)) dut (
      .clkIn  (clk),
      .rstnIn (rstn),
      .rxBus  (bus)
   );

   task automatic check(input string name, input longint act, input longint req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic waitCyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: classify a frame from its fields and queue the event it must produce.
   task automatic sendFrame(input logic [7:0] b, input logic stopBit, input logic parBit);
      expEv_t e;
      e.startCyc = cyc;
`ifdef UART_RX_PARITY_EN
      if (parBit != ^b)      e.kind = EV_PERR;
      else
`endif
      if (!stopBit)          e.kind = EV_FERR;
      else                   e.kind = EV_VALID;
      if (e.kind == EV_VALID) lastGood = b;
      e.data = lastGood;
      sbQ.push_back(e);
      $display("[TB] send byte %02h stop=%0b par=%0b expect kind=%0d data=%02h",
               b, stopBit, parBit, e.kind, e.data);
      bus.dataIn = 1'b0;
      waitCyc(CPB);
      for (int i = 0; i < 8; i++) begin
         bus.dataIn = b[i];
         waitCyc(CPB);
      end
`ifdef UART_RX_PARITY_EN
      bus.dataIn = parBit;
      waitCyc(CPB);
`endif
      bus.dataIn = stopBit;
      waitCyc(CPB);
      bus.dataIn = 1'b1;
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 4 * LAT && sbQ.size() != 0; i++) @(posedge clk);
      #1;
      check({name, "_drain"}, sbQ.size(), 0);
   endtask

   task automatic checkIdleOutputs(input string name);
      check({name, "_data"},   bus.dataOut, 8'h00);
      check({name, "_valid"},  bus.validOut, 1'b0);
      check({name, "_ferr"},   bus.frameErrOut, 1'b0);
      check({name, "_perr"},   bus.parityErrOut, 1'b0);
      check({name, "_busy"},   bus.busyOut, 1'b0);
   endtask

   // Output monitor
   int      nPulse;
   expEv_t  popped;
   evKind_t gotKind;
   always @(negedge clk) begin
      if (rstn) begin
         nPulse = int'(bus.validOut) + int'(bus.frameErrOut) + int'(bus.parityErrOut);
         if (nPulse != 0) begin
            check("pulse_exclusive", nPulse, 1);
            gotKind = bus.validOut ? EV_VALID : (bus.frameErrOut ? EV_FERR : EV_PERR);
            if (sbQ.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_pulse: got kind %0d data %02h, required no pulse (cycle %0d)",
                        gotKind, bus.dataOut, cyc);
            end else begin
               popped = sbQ.pop_front();
               $display("[TB] event kind=%0d data=%02h latency=%0d", gotKind, bus.dataOut,
                        cyc - popped.startCyc);
               check("event_kind", gotKind, popped.kind);
               check("event_data", bus.dataOut, popped.data);
               tests++;
               if ((cyc - popped.startCyc) < LAT - 1 || (cyc - popped.startCyc) > LAT + 1) begin
                  fails++;
                  $display("FAIL latency: got %0d, required %0d +/-1", cyc - popped.startCyc, LAT);
               end
            end
         end
      end
   end

   initial begin
      logic [7:0] rb;
      logic       rs;
      logic       rp;
      int         busyWait;
      bus.dataIn = 1'b1;
      rstn = 1'b0;
      waitCyc(5);
      checkIdleOutputs("reset");
      rstn = 1'b1;
      waitCyc(10);

      // Basic frame
      sendFrame(8'h41, 1'b1, ^8'h41);
      drain("f41");
      check("f41_busy_after", bus.busyOut, 1'b0);
      check("f41_dataOut", bus.dataOut, 8'h41);

      // Short low glitch must not produce a frame
      bus.dataIn = 1'b0;
      waitCyc(50);
      bus.dataIn = 1'b1;
      busyWait = 0;
      while (bus.busyOut && busyWait < 120) begin
         waitCyc(1);
         busyWait++;
      end
      check("glitch_busy_low", bus.busyOut, 1'b0);
      waitCyc(2 * CPB);
      check("glitch_dataOut", bus.dataOut, 8'h41);

      // Stop bit low: frame error, dataOut keeps 0x41
      sendFrame(8'h55, 1'b0, ^8'h55);
      waitCyc(CPB);
      drain("f55_ferr");
      check("f55_dataOut_kept", bus.dataOut, 8'h41);

      // Back-to-back frames without idle gap
      sendFrame(8'h00, 1'b1, ^8'h00);
      sendFrame(8'hFF, 1'b1, ^8'hFF);
      drain("b2b");
      check("b2b_dataOut", bus.dataOut, 8'hFF);

      // Reset during data bit 4, then a fresh frame
      rb = 8'h3C;
      bus.dataIn = 1'b0;
      waitCyc(CPB);
      for (int i = 0; i < 4; i++) begin
         bus.dataIn = rb[i];
         waitCyc(CPB);
      end
      bus.dataIn = rb[4];
      waitCyc(HALF);
      rstn = 1'b0;
      bus.dataIn = 1'b1;
      waitCyc(2);
      checkIdleOutputs("midreset");
      waitCyc(5);
      lastGood = 8'h00;
      rstn = 1'b1;
      waitCyc(CPB);
      check("postreset_quiet", sbQ.size(), 0);
      sendFrame(8'hA5, 1'b1, ^8'hA5);
      drain("fA5");
      check("fA5_dataOut", bus.dataOut, 8'hA5);

`ifdef UART_RX_PARITY_EN
      sendFrame(8'h03, 1'b1, 1'b1);
      waitCyc(CPB);
      sendFrame(8'h03, 1'b1, 1'b0);
      drain("parity");
      check("parity_dataOut", bus.dataOut, 8'h03);
`endif

      // Randomized frames with random gaps, occasional bad stop or parity bits
      for (int n = 0; n < 10; n++) begin
         rb = 8'($urandom);
         rs = ($urandom_range(0, 3) != 0);
         rp = ($urandom_range(0, 4) != 0) ? ^rb : ~^rb;
         sendFrame(rb, rs, rp);
         if (!rs)                            waitCyc(CPB + $urandom_range(0, 100));
         else if ($urandom_range(0, 1) != 0) waitCyc($urandom_range(1, 200));
      end
      drain("random");
      check("random_busy_after", bus.busyOut, 1'b0);
      check("final_dataOut", bus.dataOut, lastGood);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter CLK_FREQ, default 27000000, system clock frequency in Hz.
REQ-002 Parameter BAUD_RATE, default 115200, serial bit rate in bit/s.
REQ-003 clkIn  input  1  system clock; one clock, all logic on its rising edge.
REQ-004 rstnIn  input  1  reset; asynchronous and active-low.
REQ-005 dataIn  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 dataOut  output  8  last correctly received byte.
REQ-007 validOut  output  1  one-cycle pulse: dataOut updated with a new byte.
REQ-008 frameErrOut  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 parityErrOut  output  1  one-cycle pulse: parity mismatch; constant 0 when parity is compiled out.
REQ-010 busyOut  output  1  high while a frame is being received, i.e. in any state other than IDLE.

Function
REQ-011 CLKS_PER_BIT SHALL be CLK_FREQ/BAUD_RATE (integer division; 234 at defaults), HALF_BIT SHALL be CLKS_PER_BIT/2, and elaboration SHALL fail if CLKS_PER_BIT < 4.
REQ-012 dataIn SHALL pass through a 2-flop synchronizer before any use; all timing below refers to the synchronized line.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY (present only with the macro) and STOP.
REQ-014 IDLE: on a high-to-low transition of the line, go to START with the bit counter cleared; a line that is held low SHALL NOT start a frame.
REQ-015 START: when the counter reaches HALF_BIT-1, sample the line; if high, treat it as a glitch and return to IDLE with no pulse; if low, go to DATA with the counter and bit index cleared.
REQ-016 DATA: sample at counter == CLKS_PER_BIT-1 (mid-bit), shift the sample in LSB first, clear the counter; after the 8th bit, go to STOP (or PARITY).
REQ-017 STOP: sample at counter == CLKS_PER_BIT-1; if the sample is 1, load dataOut and pulse validOut on the next cycle; if 0, pulse frameErrOut instead and leave dataOut unchanged; in both cases return to IDLE.
REQ-018 validOut, frameErrOut and parityErrOut SHALL be mutually exclusive and SHALL each be exactly 1 cycle wide.
REQ-019 Latency: validOut SHALL rise exactly 2 + HALF_BIT + 9*CLKS_PER_BIT + 1 clocks (±1) after the falling edge on dataIn (+CLKS_PER_BIT with parity).
REQ-020 Back-to-back frames: after returning to IDLE from mid-stop-bit, the next falling edge SHALL be accepted with no idle gap.
REQ-021 The shift register SHALL NOT alter dataOut until a frame completes successfully.

Reset
REQ-022 While rstnIn = 0: state = IDLE, counters = 0, dataOut = 0x00, validOut = frameErrOut = parityErrOut = busyOut = 0, synchronizer flops = 1.
REQ-023 Reset asserted mid-frame SHALL discard the partial byte; after release, the first falling edge SHALL start a fresh frame.

Configuration
REQ-024 Macro UART_RX_PARITY_EN defined: a PARITY state follows DATA and samples an even-parity bit at mid-bit; on mismatch, STOP SHALL pulse parityErrOut (priority over frameErrOut) and validOut SHALL stay low.
REQ-025 Macro undefined: no PARITY state, frame is 8N1, and parityErrOut is tied to 0.

Structure
REQ-026 Package uart_pkg SHALL hold the state enum type, DATA_BITS = 8, and a function returning clocks-per-bit from CLK_FREQ and BAUD_RATE, shared with uart_tx.
REQ-027 The synchronizer SHALL be a separate sub-module, sync_2ff (parameterized reset value, default 1).

Verification
REQ-028 Defaults, drive an 8N1 frame for 0x41 at 234 clk/bit -> one validOut pulse, dataOut = 0x41, busyOut low afterwards, no error pulses.
REQ-029 Low glitch of 50 clocks on an idle line -> no pulses on any output, busyOut returns low within 120 clocks.
REQ-030 Frame 0x55 with the stop bit driven 0 -> frameErrOut pulses once, validOut stays 0, dataOut keeps its previous value (0x41).
REQ-031 Frames 0x00 and 0xFF sent back-to-back with no idle gap -> two validOut pulses, dataOut = 0x00 then 0xFF.
REQ-032 rstnIn pulsed low during data bit 4 of a frame, then 0xA5 sent -> all outputs 0 during reset, no pulse for the aborted frame, then validOut with dataOut = 0xA5.
REQ-033 UART_RX_PARITY_EN defined, 0x03 sent with parity bit 1 -> parityErrOut pulses once, no validOut; same byte with parity bit 0 -> validOut with dataOut = 0x03.
